regfile_alu_seq: RTL and testbench
==================================

# regfile_alu_seq

Parametrised register file with an attached sequential ALU controller; the next generation of the 8x8 register-file/ALU pair. Holds DEPTH words of WIDTH bits, accepts external writes, and executes two-operand ALU operations via a valid/ready handshake. Each operation is a fixed three-cycle read/execute/write-back sequence with registered carry and zero flags. Sits between the datapath input mux and the downstream result consumers.

## Interface
- WIDTH, 8, data word width in bits (≥2)
- DEPTH, 8, number of registers (power of two, ≥2); AW = $clog2(DEPTH)
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state on the edge where sampled high
- wr  in  1  external write request
- wr_addr  in  AW  external write address
- d_in  in  WIDTH  external write data
- wr_ack  out  1  comb: wr && !wb_en (external write taken this cycle)
- rd_addr_a, rd_addr_b  in  AW  read-port addresses
- d_out_a, d_out_b  out  WIDTH  comb array read, no write bypass
- op_valid  in  1  operation request
- op_ready  out  1  high only in IDLE
- op  in  2  00 ADD, 01 SUB, 10 AND, 11 OR
- src_a, src_b, dst  in  AW  operand and destination addresses, sampled at accept
- done  out  1  one-cycle pulse, result valid
- result  out  WIDTH  last ALU result (registered)
- cout, zero  out  1  registered flags of last completed op

## Operation
- FSM: IDLE -> (op_valid && op_ready) -> EXEC -> WB -> IDLE. No other transitions except reset.
- Accept edge: latch op, dst, mem[src_a], mem[src_b] into operand registers.
- EXEC: ALU combinational on latched operands; on exit edge register result, cout, zero.
- WB: wb_en=1; on exit edge mem[dst] <= result; done=1 during WB.
- ADD: {cout,result} = a + b (WIDTH+1 bits). SUB: {cout,result} = a + ~b + 1; cout=1 means no borrow (a ≥ b unsigned). AND/OR: cout=0. zero = (result == 0).
- Single write port: WB write has priority; external wr in a WB cycle is dropped, wr_ack=0. Otherwise external write lands at clock edge.
- Operands use pre-edge array contents: external write to src_a in the accept cycle is not seen by the operation.
- dst may equal src_a/src_b; operands are already latched, no hazard.
- op_valid outside IDLE ignored; requester holds fields until accept.

## Timing
- Reset values: all registers 0, state IDLE, op_ready=1, done=0, result=0, cout=0, zero=0. wr_ack follows wr (wb_en=0).
- Accept at cycle N -> done high in cycle N+2 -> destination readable on d_out from cycle N+3 -> op_ready high again in N+3.
- Throughput: one op per 3 cycles.
- External write at cycle N visible on d_out from cycle N+1.
- Reset in EXEC or WB: op aborted, no write-back, done stays 0, flags cleared.

## Structure
- Shared package regfile_alu_pkg: op encodings (OP_ADD/SUB/AND/OR), state enum (S_IDLE, S_EXEC, S_WB).
- One natural sub-module: alu_core (combinational, WIDTH-parametrised; op, a, b -> y, cout). Storage and FSM in top level.

## Test plan
- Reset, then read all addresses -> every d_out 0; op_ready=1, cout=0, zero=0.
- wr to r3=0xF0, r5=0x20; ADD src_a=3 src_b=5 dst=1 -> done at accept+2, result=0x10, cout=1, zero=0; r1 reads 0x10 at accept+3.
- SUB r5-r3 into r2 -> result=0x30, cout=0; SUB r3-r3 -> result=0x00, cout=1, zero=1.
- During WB of an op with dst=4, wr to addr 6 = 0xAA -> wr_ack=0, r6 unchanged, r4 holds result; repeat wr next cycle -> wr_ack=1, r6=0xAA.
- Assert reset in EXEC of ADD dst=7 -> no done, r7=0, state IDLE next cycle.
- WIDTH=16, DEPTH=32: ADD 0xFFFF + 0x0001 into r31 -> result=0x0000, cout=1, zero=1.

Source files
------------

// File: rtl/regfile_alu_pkg.sv
// Shared definitions for the register-file / sequential-ALU block:
// operation encodings and controller state encoding.
package regfile_alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_e;

endpackage

// File: rtl/regfile_alu_seq_alu_core.sv
// Combinational two-operand ALU; cout is carry for ADD, not-borrow for SUB,
// and 0 for the logic operations.
module alu_core
  import regfile_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             cout
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum  = '0;
    y    = '0;
    cout = 1'b0;
    case (op)
      OP_ADD: begin
        sum  = {1'b0, a} + {1'b0, b};
        y    = sum[WIDTH-1:0];
        cout = sum[WIDTH];
      end
      OP_SUB: begin
        // two's-complement subtract so the carry out reads as "no borrow"
        sum  = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        y    = sum[WIDTH-1:0];
        cout = sum[WIDTH];
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/regfile_alu_seq.sv
// Register file with a three-cycle read/execute/write-back ALU controller.
// Single write port: the write-back slot always wins over an external write.
module regfile_alu_seq
  import regfile_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] d_in,
  output logic             wr_ack,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] d_out_a,
  output logic [WIDTH-1:0] d_out_b,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [1:0]       op,
  input  logic [AW-1:0]    src_a,
  input  logic [AW-1:0]    src_b,
  input  logic [AW-1:0]    dst,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output state_e           state_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  state_e           state_q, state_d;
  logic [1:0]       op_q;
  logic [AW-1:0]    dst_q;
  logic [WIDTH-1:0] opa_q, opb_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q, zero_q;
  logic [WIDTH-1:0] alu_y;
  logic             alu_cout;
  logic             wb_en;
  logic             accept;

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .op   (op_q),
    .a    (opa_q),
    .b    (opb_q),
    .y    (alu_y),
    .cout (alu_cout)
  );

  // Handshake: an op transfers on the rising edge where op_valid && op_ready;
  // op_ready is high only in IDLE, and the requester holds its fields until then.
  assign accept   = op_valid && (state_q == S_IDLE);
  assign op_ready = (state_q == S_IDLE);
  assign wb_en    = (state_q == S_WB);
  assign done     = wb_en;
  assign wr_ack   = wr && !wb_en;
  assign d_out_a  = mem_q[rd_addr_a];
  assign d_out_b  = mem_q[rd_addr_b];
  assign result   = result_q;
  assign cout     = cout_q;
  assign zero     = zero_q;
  assign state_o  = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (op_valid) state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      dst_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      // operands come from pre-edge contents, so a same-cycle external write is not seen
      if (accept) begin
        op_q  <= op;
        dst_q <= dst;
        opa_q <= mem_q[src_a];
        opb_q <= mem_q[src_b];
      end
      if (state_q == S_EXEC) begin
        result_q <= alu_y;
        cout_q   <= alu_cout;
        zero_q   <= (alu_y == '0);
      end
      if (wb_en) mem_q[dst_q] <= result_q;
      else if (wr) mem_q[wr_addr] <= d_in;
    end
  end

endmodule

// File: tb/tb_regfile_alu_seq.sv
// Directed bench for regfile_alu_seq: an 8x8 instance for the main scenarios
// and a 16x32 instance for the wide carry/zero corner.
module tb_regfile_alu_seq;
  import regfile_alu_pkg::*;

  int checks_total  = 0;
  int checks_passed = 0;
  logic [31:0] exp_q[$];

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 8x8 instance
  logic       wr, wr_ack, op_valid, op_ready, done, cout, zero;
  logic [2:0] wr_addr, rd_addr_a, rd_addr_b, src_a, src_b, dst;
  logic [7:0] d_in, d_out_a, d_out_b, result;
  logic [1:0] op;
  state_e     state_o;

  regfile_alu_seq #(.WIDTH(8), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .wr(wr), .wr_addr(wr_addr), .d_in(d_in),
    .wr_ack(wr_ack), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .d_out_a(d_out_a), .d_out_b(d_out_b), .op_valid(op_valid),
    .op_ready(op_ready), .op(op), .src_a(src_a), .src_b(src_b), .dst(dst),
    .done(done), .result(result), .cout(cout), .zero(zero), .state_o(state_o)
  );

  // 16x32 instance
  logic        w_wr, w_wr_ack, w_op_valid, w_op_ready, w_done, w_cout, w_zero;
  logic [4:0]  w_wr_addr, w_rd_addr_a, w_rd_addr_b, w_src_a, w_src_b, w_dst;
  logic [15:0] w_d_in, w_d_out_a, w_d_out_b, w_result;
  logic [1:0]  w_op;
  state_e      w_state_o;

  regfile_alu_seq #(.WIDTH(16), .DEPTH(32)) dut_w (
    .clk(clk), .reset(reset), .wr(w_wr), .wr_addr(w_wr_addr), .d_in(w_d_in),
    .wr_ack(w_wr_ack), .rd_addr_a(w_rd_addr_a), .rd_addr_b(w_rd_addr_b),
    .d_out_a(w_d_out_a), .d_out_b(w_d_out_b), .op_valid(w_op_valid),
    .op_ready(w_op_ready), .op(w_op), .src_a(w_src_a), .src_b(w_src_b),
    .dst(w_dst), .done(w_done), .result(w_result), .cout(w_cout),
    .zero(w_zero), .state_o(w_state_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks (8x8 instance)
  task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
    wr = 1'b1; wr_addr = a; d_in = d;
    #1 check("wr_ack", 32'(wr_ack), 32'd1);
    tick();
    wr = 1'b0;
    rd_addr_b = a;
    #1 check("wr_visible", 32'(d_out_b), 32'(d));
  endtask

  task automatic issue_op(input logic [1:0] o, input logic [2:0] a, input logic [2:0] b,
                          input logic [2:0] d);
    op = o; src_a = a; src_b = b; dst = d; op_valid = 1'b1;
    #1 check("op_ready_idle", 32'(op_ready), 32'd1);
    tick();
    op_valid = 1'b0;
    #1 check("exec_no_done", 32'(done), 32'd0);
  endtask

  // full op: accept -> EXEC -> WB (done, flags) -> IDLE (dst readable)
  task automatic run_op(input string tag, input logic [1:0] o, input logic [2:0] a,
                        input logic [2:0] b, input logic [2:0] d, input logic [7:0] er,
                        input logic ec, input logic ez);
    exp_q.push_back({22'd0, ez, ec, er});
    issue_op(o, a, b, d);
    tick();
    check({tag, "_done"}, 32'(done), 32'd1);
    if (exp_q.size() > 0) check({tag, "_flags_res"}, {22'd0, zero, cout, result}, exp_q.pop_front());
    tick();
    rd_addr_a = d;
    #1 check({tag, "_dst"}, 32'(d_out_a), 32'(er));
    check({tag, "_ready_back"}, 32'(op_ready), 32'd1);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    reset = 1'b1; wr = 0; wr_addr = 0; d_in = 0; rd_addr_a = 0; rd_addr_b = 0;
    op_valid = 0; op = 0; src_a = 0; src_b = 0; dst = 0;
    w_wr = 0; w_wr_addr = 0; w_d_in = 0; w_rd_addr_a = 0; w_rd_addr_b = 0;
    w_op_valid = 0; w_op = 0; w_src_a = 0; w_src_b = 0; w_dst = 0;
    tick(); tick();
    reset = 1'b0;
    #1;

    // reset state
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i);
      #1 check("rst_rd_a", 32'(d_out_a), 32'd0);
      check("rst_rd_b", 32'(d_out_b), 32'd0);
    end
    check("rst_ready", 32'(op_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_state", 32'(state_o), 32'(S_IDLE));

    // basic arithmetic
    write_reg(3'd3, 8'hF0);
    write_reg(3'd5, 8'h20);
    run_op("add", OP_ADD, 3'd3, 3'd5, 3'd1, 8'h10, 1'b1, 1'b0);
    run_op("sub_borrow", OP_SUB, 3'd5, 3'd3, 3'd2, 8'h30, 1'b0, 1'b0);
    run_op("sub_self", OP_SUB, 3'd3, 3'd3, 3'd0, 8'h00, 1'b1, 1'b1);
    run_op("and", OP_AND, 3'd3, 3'd1, 3'd6, 8'h10, 1'b0, 1'b0);
    run_op("or", OP_OR, 3'd3, 3'd5, 3'd6, 8'hF0, 1'b0, 1'b0);
    run_op("sub_gt", OP_SUB, 3'd3, 3'd5, 3'd6, 8'hD0, 1'b1, 1'b0);
    run_op("dst_eq_src", OP_ADD, 3'd5, 3'd5, 3'd5, 8'h40, 1'b0, 1'b0);

    // write dropped during WB; r6 currently 0xD0 -> overwritten by op below? no: dst=4
    issue_op(OP_ADD, 3'd5, 3'd5, 3'd4);   // r5=0x40 -> 0x80
    tick();                               // WB
    wr = 1'b1; wr_addr = 3'd6; d_in = 8'hAA;
    #1 check("wb_wr_ack", 32'(wr_ack), 32'd0);
    check("wb_done", 32'(done), 32'd1);
    check("wb_result", 32'(result), 32'h80);
    tick();
    rd_addr_a = 3'd6; rd_addr_b = 3'd4;
    #1 check("wb_r6_kept", 32'(d_out_a), 32'hD0);
    check("wb_r4", 32'(d_out_b), 32'h80);
    check("retry_wr_ack", 32'(wr_ack), 32'd1);
    tick();
    wr = 1'b0;
    #1 check("retry_r6", 32'(d_out_a), 32'hAA);

    // same-cycle external write to src_a is not seen by the op
    wr = 1'b1; wr_addr = 3'd3; d_in = 8'h01;
    issue_op(OP_ADD, 3'd3, 3'd5, 3'd7);   // 0xF0 + 0x40 = 0x130
    wr = 1'b0;
    tick();
    check("pre_edge_res", 32'(result), 32'h30);
    check("pre_edge_cout", 32'(cout), 32'd1);
    tick();
    rd_addr_a = 3'd7; rd_addr_b = 3'd3;
    #1 check("pre_edge_r7", 32'(d_out_a), 32'h30);
    check("pre_edge_r3", 32'(d_out_b), 32'h01);

    // reset during EXEC aborts the op
    write_reg(3'd2, 8'h11);
    issue_op(OP_ADD, 3'd2, 3'd2, 3'd7);
    check("abort_in_exec", 32'(state_o), 32'(S_EXEC));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd_addr_a = 3'd7;
    #1 check("abort_state", 32'(state_o), 32'(S_IDLE));
    check("abort_done", 32'(done), 32'd0);
    check("abort_r7", 32'(d_out_a), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_zero", 32'(zero), 32'd0);
    tick();
    #1 check("abort_done_after", 32'(done), 32'd0);
    check("abort_r7_after", 32'(d_out_a), 32'd0);

    // wide instance: 0xFFFF + 0x0001 into r31
    w_wr = 1'b1; w_wr_addr = 5'd10; w_d_in = 16'hFFFF; tick();
    w_wr_addr = 5'd11; w_d_in = 16'h0001; tick();
    w_wr_addr = 5'd31; w_d_in = 16'h1234; tick();
    w_wr = 1'b0; w_rd_addr_a = 5'd31;
    #1 check("w_r31_pre", 32'(w_d_out_a), 32'h1234);
    w_op = OP_ADD; w_src_a = 5'd10; w_src_b = 5'd11; w_dst = 5'd31; w_op_valid = 1'b1;
    tick();
    w_op_valid = 1'b0;
    tick();
    check("w_done", 32'(w_done), 32'd1);
    check("w_result", 32'(w_result), 32'h0000);
    check("w_cout", 32'(w_cout), 32'd1);
    check("w_zero", 32'(w_zero), 32'd1);
    tick();
    check("w_r31", 32'(w_d_out_a), 32'h0000);
    check("w_ready", 32'(w_op_ready), 32'd1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
